pipelined_regfile_param: RTL and testbench
==========================================

# pipelined_regfile_param

Parametrised 3-stage (ID/EXE/WB) register-file + ALU datapath, the generalised successor of the fixed 16-bit pipelined register-file core. It accepts pre-decoded instructions over a valid/ready handshake. It reads operands from a NREGS-entry register file and executes them on a DATA_W ALU. Results are written back with configurable hazard handling: forwarding or stalling. A saturating stall counter and a debug read port support bench observation.

## Interface
- DATA_W, 16, datapath and register width (≥4, power of two)
- NREGS, 16, number of registers; address width AW = clog2(NREGS)
- FORWARD, 1, 1 = EXE→ID forwarding; 0 = interlock (stall) on EXE hazard
- ZERO_REG, 1, 1 = r0 reads as 0 and writes to r0 are dropped
- STALL_W, 8, stall counter width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  instruction present
- in_ready  out  1  instruction accepted on the edge where in_valid & in_ready
- in_op  in  3  ALU op
- in_rd, in_rs, in_rt  in  AW each  destination and source registers
- in_imm  in  DATA_W  immediate
- in_alusrc  in  1  1 = operand B is in_imm, 0 = reg[rt]
- in_wen  in  1  instruction writes rd
- wb_valid  out  1  retiring instruction with wen=1 this cycle
- wb_addr  out  AW  its rd
- wb_data  out  DATA_W  its result
- stall_cnt  out  STALL_W  cycles with in_valid=1 and in_ready=0 (saturating)
- dbg_addr  in  AW  debug read address
- dbg_rdata  out  DATA_W  combinational reg[dbg_addr] (0 for r0 when ZERO_REG)

## Operation
- Stages: ID (accept and read operands) → ID_EXE register → ALU (combinational) → EXE_WB register → regfile write on the next edge.
- ALU, modulo 2^DATA_W. A = reg[rs]. B = in_imm if alusrc, else reg[rt].
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL by B[clog2(DATA_W)-1:0], 6 SRL (logical), same shift amount.
  - 7 SLT signed, result 1 or 0.
- Operand source priority for rs, and for rt when alusrc=0:
  - r0 with ZERO_REG → 0.
  - Match with ID_EXE (valid, wen, rd) and FORWARD=1 → live ALU output.
  - Match with EXE_WB (valid, wen, rd) → EXE_WB result. This write-through bypass is always on.
  - Otherwise → register file.
- FORWARD=0 hazard: an ID_EXE match drives in_ready=0. ID_EXE becomes a bubble (valid=0) on the next edge. The instruction is accepted the following cycle through the EXE_WB bypass, giving exactly 1 stall cycle.
- Hazard never raised for r0 (ZERO_REG=1), for rt when alusrc=1, or when the producer has wen=0.
- in_ready = !rst & !hazard. It is always 1 when FORWARD=1.
- Instructions with wen=0 flow through the pipeline but never assert wb_valid.
- Writes to r0 with ZERO_REG=1 still assert wb_valid (wb_addr=0, computed data), but the regfile is unchanged.
- stall_cnt increments each cycle in_valid & !in_ready & !rst, and holds at 2^STALL_W−1.

## Timing
- Reset (rst high at an edge): all registers 0, ID_EXE/EXE_WB valid 0, stall_cnt 0.
- Reset output values: wb_valid 0, wb_addr 0, wb_data 0, in_ready 0 while rst=1.
- Reset mid-operation: in-flight instructions are discarded with no regfile write. An instruction presented during rst is not accepted.
- Accept at edge N: ID_EXE valid from N. EXE_WB valid from N+1, so wb_* is valid in the cycle after N+1 (latency 2). Regfile updated at edge N+2, visible on dbg_rdata from then.
- Throughput 1 instruction/cycle absent FORWARD=0 stalls.
- in_ready is combinational from in_rs/in_rt/in_alusrc and pipeline state. in_valid must be held with stable fields until accepted.

## Test plan
- FORWARD=1: ADD r1=r0+imm 5; ADD r2=r1+r1 back-to-back → wb (1,5) then (2,10) on consecutive cycles; stall_cnt=0; dbg r2=10.
- FORWARD=0, same stream → in_ready low exactly 1 cycle, stall_cnt=1, wb (1,5) then (2,10) separated by one empty cycle.
- Wrap and compare: r1=0+imm 0xFFFF; ADD r2=r1+imm 1 → 0x0000; SLT r3=r1<r0 → 1; SRL r4=r1 by imm 4 → 0x0FFF.
- WB bypass: r1=imm 7; independent r5=imm 1; ADD r2=r1+imm 3 → r2=10, no stall in either FORWARD mode.
- ZERO_REG: ADD r0=r0+imm 9 → wb_valid with addr 0/data 9; dbg r0=0; next ADD r1=r0+imm 1 → 1.
- Reset mid-flight: two instructions accepted, then rst pulsed for 1 cycle → no wb_valid afterward, all dbg reads 0, stall_cnt 0.

Source files
------------

// File: rtl/pipelined_regfile_param.sv
// Three-stage (ID / EXE / WB) register file plus ALU with a valid/ready instruction port.
// EXE hazards are either forwarded from the live ALU output or resolved by a one-cycle interlock.
module pipelined_regfile_param #(
    parameter int DATA_W   = 16,
    parameter int NREGS    = 16,
    parameter int FORWARD  = 1,
    parameter int ZERO_REG = 1,
    parameter int STALL_W  = 8,
    localparam int AW      = $clog2(NREGS),
    localparam int SHW     = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [AW-1:0]     in_rd,
    input  logic [AW-1:0]     in_rs,
    input  logic [AW-1:0]     in_rt,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_alusrc,
    input  logic              in_wen,
    output logic              wb_valid,
    output logic [AW-1:0]     wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [STALL_W-1:0] stall_cnt,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_rdata
);
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_SLT = 3'd7;

    logic [DATA_W-1:0]  rf_q [NREGS];
    logic [DATA_W-1:0]  rf_d [NREGS];
    logic               ide_valid_q, ide_valid_d, ide_wen_q, ide_wen_d;
    logic [AW-1:0]      ide_rd_q, ide_rd_d;
    logic [2:0]         ide_op_q, ide_op_d;
    logic [DATA_W-1:0]  ide_a_q, ide_a_d, ide_b_q, ide_b_d;
    logic               ewb_valid_q, ewb_valid_d, ewb_wen_q, ewb_wen_d;
    logic [AW-1:0]      ewb_rd_q, ewb_rd_d;
    logic [DATA_W-1:0]  ewb_res_q, ewb_res_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic [DATA_W-1:0]  alu_y, opa, opb;
    logic rs_zero, rt_zero, rs_hit_ide, rt_hit_ide, rs_hit_ewb, rt_hit_ewb;
    logic hazard, accept;

    always_comb begin
        rs_zero    = (ZERO_REG != 0) && (in_rs == '0);
        rt_zero    = (ZERO_REG != 0) && (in_rt == '0);
        rs_hit_ide = ide_valid_q && ide_wen_q && (ide_rd_q == in_rs);
        rt_hit_ide = ide_valid_q && ide_wen_q && (ide_rd_q == in_rt);
        rs_hit_ewb = ewb_valid_q && ewb_wen_q && (ewb_rd_q == in_rs);
        rt_hit_ewb = ewb_valid_q && ewb_wen_q && (ewb_rd_q == in_rt);
        // Without forwarding, a producer still in EXE blocks the consumer for one cycle.
        hazard = (FORWARD == 0) &&
                 ((!rs_zero && rs_hit_ide) || (!in_alusrc && !rt_zero && rt_hit_ide));
        in_ready = !rst && !hazard;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        opa = rf_q[in_rs];
        if (rs_zero)                         opa = '0;
        else if (FORWARD != 0 && rs_hit_ide) opa = alu_y;
        else if (rs_hit_ewb)                 opa = ewb_res_q;

        opb = rf_q[in_rt];
        if (in_alusrc)                       opb = in_imm;
        else if (rt_zero)                    opb = '0;
        else if (FORWARD != 0 && rt_hit_ide) opb = alu_y;
        else if (rt_hit_ewb)                 opb = ewb_res_q;
    end

    always_comb begin
        alu_y = '0;
        case (ide_op_q)
            OP_ADD:  alu_y = ide_a_q + ide_b_q;
            OP_SUB:  alu_y = ide_a_q - ide_b_q;
            OP_AND:  alu_y = ide_a_q & ide_b_q;
            OP_OR:   alu_y = ide_a_q | ide_b_q;
            OP_XOR:  alu_y = ide_a_q ^ ide_b_q;
            OP_SLL:  alu_y = ide_a_q << ide_b_q[SHW-1:0];
            OP_SRL:  alu_y = ide_a_q >> ide_b_q[SHW-1:0];
            OP_SLT:  alu_y = {{(DATA_W-1){1'b0}}, ($signed(ide_a_q) < $signed(ide_b_q))};
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        ide_valid_d = accept;
        ide_wen_d   = in_wen;
        ide_rd_d    = in_rd;
        ide_op_d    = in_op;
        ide_a_d     = opa;
        ide_b_d     = opb;
        ewb_valid_d = ide_valid_q;
        ewb_wen_d   = ide_wen_q;
        ewb_rd_d    = ide_rd_q;
        ewb_res_d   = alu_y;
        rf_d        = rf_q;
        // r0 writes still retire on the wb port but never land in the array.
        if (ewb_valid_q && ewb_wen_q && !((ZERO_REG != 0) && (ewb_rd_q == '0)))
            rf_d[ewb_rd_q] = ewb_res_q;
        stall_d = stall_q;
        if (in_valid && !in_ready && !rst && (stall_q != '1))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ide_valid_q <= 1'b0;
            ide_wen_q   <= 1'b0;
            ide_rd_q    <= '0;
            ide_op_q    <= '0;
            ide_a_q     <= '0;
            ide_b_q     <= '0;
            ewb_valid_q <= 1'b0;
            ewb_wen_q   <= 1'b0;
            ewb_rd_q    <= '0;
            ewb_res_q   <= '0;
            stall_q     <= '0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            ide_valid_q <= ide_valid_d;
            ide_wen_q   <= ide_wen_d;
            ide_rd_q    <= ide_rd_d;
            ide_op_q    <= ide_op_d;
            ide_a_q     <= ide_a_d;
            ide_b_q     <= ide_b_d;
            ewb_valid_q <= ewb_valid_d;
            ewb_wen_q   <= ewb_wen_d;
            ewb_rd_q    <= ewb_rd_d;
            ewb_res_q   <= ewb_res_d;
            stall_q     <= stall_d;
            rf_q        <= rf_d;
        end
    end

    assign wb_valid  = !rst && ewb_valid_q && ewb_wen_q;
    assign wb_addr   = rst ? '0 : ewb_rd_q;
    assign wb_data   = rst ? '0 : ewb_res_q;
    assign stall_cnt = stall_q;
    assign dbg_rdata = ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 : rf_q[dbg_addr];
endmodule

// File: tb/tb_pipelined_regfile_param.sv
// Bench for pipelined_regfile_param: a forwarding and an interlocking instance share one stimulus bus
// (sel picks the active one) and are checked against an in-order architectural model with a timed wb queue.
module tb_pipelined_regfile_param;
    localparam int DW = 16;
    localparam int NR = 16;
    localparam int AW = 4;
    localparam int SW = 8;
    localparam longint MOD = 65536;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SRL = 3'd6, OP_SLT = 3'd7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sel = 1'b0;
    logic          in_valid = 1'b0;
    logic [2:0]    in_op = '0;
    logic [AW-1:0] in_rd = '0, in_rs = '0, in_rt = '0, dbg_addr = '0;
    logic [DW-1:0] in_imm = '0;
    logic          in_alusrc = 1'b0, in_wen = 1'b0;
    logic          v_f, v_s;

    logic          in_ready_f, in_ready_s, wb_valid_f, wb_valid_s;
    logic [AW-1:0] wb_addr_f, wb_addr_s;
    logic [DW-1:0] wb_data_f, wb_data_s, dbg_rdata_f, dbg_rdata_s;
    logic [SW-1:0] stall_cnt_f, stall_cnt_s;

    logic          in_ready, wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data, dbg_rdata;
    logic [SW-1:0] stall_cnt;

    assign v_f       = in_valid & ~sel;
    assign v_s       = in_valid & sel;
    assign in_ready  = sel ? in_ready_s  : in_ready_f;
    assign wb_valid  = sel ? wb_valid_s  : wb_valid_f;
    assign wb_addr   = sel ? wb_addr_s   : wb_addr_f;
    assign wb_data   = sel ? wb_data_s   : wb_data_f;
    assign dbg_rdata = sel ? dbg_rdata_s : dbg_rdata_f;
    assign stall_cnt = sel ? stall_cnt_s : stall_cnt_f;

    pipelined_regfile_param #(.DATA_W(DW), .NREGS(NR), .FORWARD(1), .ZERO_REG(1), .STALL_W(SW)) dut_f (
        .clk(clk), .rst(rst), .in_valid(v_f), .in_ready(in_ready_f), .in_op(in_op),
        .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm), .in_alusrc(in_alusrc),
        .in_wen(in_wen), .wb_valid(wb_valid_f), .wb_addr(wb_addr_f), .wb_data(wb_data_f),
        .stall_cnt(stall_cnt_f), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata_f));

    pipelined_regfile_param #(.DATA_W(DW), .NREGS(NR), .FORWARD(0), .ZERO_REG(1), .STALL_W(SW)) dut_s (
        .clk(clk), .rst(rst), .in_valid(v_s), .in_ready(in_ready_s), .in_op(in_op),
        .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm), .in_alusrc(in_alusrc),
        .in_wen(in_wen), .wb_valid(wb_valid_s), .wb_addr(wb_addr_s), .wb_data(wb_data_s),
        .stall_cnt(stall_cnt_s), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata_s));

    // clock / reset
    int cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // reference model state and scoreboard
    logic [DW-1:0] m_regs [NR];
    int            m_stall = 0;
    logic          prev_valid = 1'b0, prev_wen = 1'b0;
    logic [AW-1:0] prev_rd = '0;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int            exp_due_q[$];
    int            n_checks = 0, n_fail = 0;
    logic          mon_exp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (sel=%0d cycle %0d)", tag, got, exp, sel, cyc);
        end
    endtask

    function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        longint ia, ib, sa, sb, r;
        int sh;
        ia = longint'(a);
        ib = longint'(b);
        sa = (ia >= MOD / 2) ? ia - MOD : ia;
        sb = (ib >= MOD / 2) ? ib - MOD : ib;
        sh = int'(ib % DW);
        case (op)
            3'd0:    r = (ia + ib) % MOD;
            3'd1:    r = (ia - ib + MOD) % MOD;
            3'd2:    r = longint'(a & b);
            3'd3:    r = longint'(a | b);
            3'd4:    r = longint'(a ^ b);
            3'd5:    r = (ia * (longint'(2) ** sh)) % MOD;
            3'd6:    r = ia / (longint'(2) ** sh);
            default: r = (sa < sb) ? 1 : 0;
        endcase
        return r[DW-1:0];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        exp_q.delete();
        exp_addr_q.delete();
        exp_due_q.delete();
        prev_valid = 1'b0;
        m_stall = 0;
    endtask

    // driver tasks
    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_wb_valid", wb_valid, 0);
        check_eq("rst_wb_addr", wb_addr, 0);
        check_eq("rst_wb_data", wb_data, 0);
        check_eq("rst_stall_cnt", stall_cnt, 0);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        prev_valid = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                         input logic [AW-1:0] rt, input logic [DW-1:0] imm, input logic alusrc,
                         input logic wen);
        logic exp_rdy, done;
        logic [DW-1:0] a, b, r;
        in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
        in_imm = imm; in_alusrc = alusrc; in_wen = wen;
        in_valid = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 6 && !done; t++) begin
            @(negedge clk);
            // only the interlocking core waits, and only on a non-r0 read of the previous cycle's result
            exp_rdy = !(sel && prev_valid && prev_wen && prev_rd != '0 &&
                        (prev_rd == rs || (!alusrc && prev_rd == rt)));
            check_eq("in_ready", in_ready, exp_rdy);
            if (in_ready) begin
                a = m_regs[rs];
                b = alusrc ? imm : m_regs[rt];
                r = ref_alu(op, a, b);
                if (wen) begin
                    exp_q.push_back(r);
                    exp_addr_q.push_back(rd);
                    exp_due_q.push_back(cyc + 2);
                    if (rd != '0) m_regs[rd] = r;
                end
                prev_valid = 1'b1;
                prev_wen = wen;
                prev_rd = rd;
                done = 1'b1;
            end else begin
                m_stall++;
                prev_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: instruction not accepted within 6 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic check_dbg(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        @(negedge clk);
        dbg_addr = addr;
        #1;
        check_eq($sformatf("dbg_r%0d", addr), dbg_rdata, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs();
        for (int i = 0; i < NR; i++) check_dbg(AW'(i), m_regs[i]);
    endtask

    // scoreboard: every retirement must occur exactly on its due cycle
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_due_q.size() > 0 && exp_due_q[0] < cyc) begin
                void'(exp_q.pop_front());
                void'(exp_addr_q.pop_front());
                void'(exp_due_q.pop_front());
            end
            mon_exp = 1'b0;
            if (exp_due_q.size() > 0) mon_exp = (exp_due_q[0] == cyc);
            check_eq("wb_valid", wb_valid, mon_exp);
            if (mon_exp) begin
                check_eq("wb_addr", wb_addr, exp_addr_q.pop_front());
                check_eq("wb_data", wb_data, exp_q.pop_front());
                void'(exp_due_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        for (int m = 0; m < 2; m++) begin
            sel = m[0];

            // dependent back-to-back ADDs
            do_reset();
            issue(OP_ADD, 4'd1, 4'd0, 4'd0, 16'd5, 1'b1, 1'b1);
            issue(OP_ADD, 4'd2, 4'd1, 4'd1, 16'd0, 1'b0, 1'b1);
            idle(4);
            check_eq("stall_cnt_dep", stall_cnt, m);
            check_dbg(4'd2, 16'd10);

            // wrap-around and signed compare
            do_reset();
            issue(OP_ADD, 4'd1, 4'd0, 4'd0, 16'hFFFF, 1'b1, 1'b1);
            issue(OP_ADD, 4'd2, 4'd1, 4'd0, 16'd1, 1'b1, 1'b1);
            issue(OP_SLT, 4'd3, 4'd1, 4'd0, 16'd0, 1'b0, 1'b1);
            issue(OP_SRL, 4'd4, 4'd1, 4'd0, 16'd4, 1'b1, 1'b1);
            idle(4);
            check_dbg(4'd2, 16'h0000);
            check_dbg(4'd3, 16'h0001);
            check_dbg(4'd4, 16'h0FFF);

            // EXE_WB bypass with an independent instruction in between
            do_reset();
            issue(OP_ADD, 4'd1, 4'd0, 4'd0, 16'd7, 1'b1, 1'b1);
            issue(OP_ADD, 4'd5, 4'd0, 4'd0, 16'd1, 1'b1, 1'b1);
            issue(OP_ADD, 4'd2, 4'd1, 4'd0, 16'd3, 1'b1, 1'b1);
            idle(4);
            check_eq("stall_cnt_byp", stall_cnt, 0);
            check_dbg(4'd2, 16'd10);

            // r0 is hard-wired to zero but its writes still retire
            do_reset();
            issue(OP_ADD, 4'd0, 4'd0, 4'd0, 16'd9, 1'b1, 1'b1);
            issue(OP_ADD, 4'd1, 4'd0, 4'd0, 16'd1, 1'b1, 1'b1);
            idle(4);
            check_dbg(4'd0, 16'd0);
            check_dbg(4'd1, 16'd1);

            // randomized stream against the model
            do_reset();
            repeat (150) begin
                if ($urandom_range(0, 7) == 0) idle(1);
                issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                      4'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) != 0));
            end
            idle(4);
            check_regs();
            check_eq("stall_cnt_rand", stall_cnt, m_stall);

            // reset while two instructions are in flight
            do_reset();
            issue(OP_ADD, 4'd1, 4'd0, 4'd0, 16'd5, 1'b1, 1'b1);
            issue(OP_ADD, 4'd2, 4'd0, 4'd0, 16'd6, 1'b1, 1'b1);
            rst = 1'b1;
            in_valid = 1'b1;
            clear_model();
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            rst = 1'b0;
            idle(4);
            check_regs();
            check_eq("stall_cnt_rst", stall_cnt, 0);
        end
        check_eq("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
